// File: rtl/sprite_issue_arbiter.sv
// ============================================================================
//  sprite_issue_arbiter : cursor-first, budgeted sprite issue to graphics
//  Rev 1.0
// ============================================================================
`default_nettype none

module sprite_issue_arbiter #(
    parameter int CANVAS_WIDTH  = 360,
    parameter int CANVAS_HEIGHT = 720,
    parameter int NUM_FRAMES    = 5,
    parameter int MAX_SPRITES   = 64,
    parameter int CURSOR_FRAME  = 0,
    localparam int XW = $clog2(CANVAS_WIDTH),
    localparam int YW = $clog2(CANVAS_HEIGHT),
    localparam int FW = $clog2(NUM_FRAMES),
    localparam int CW = $clog2(MAX_SPRITES + 1)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          new_frame,
    input  logic          cursor_en,
    input  logic [XW-1:0] cursor_x,
    input  logic [YW-1:0] cursor_y,
    input  logic          req_valid,
    input  logic [XW-1:0] req_x,
    input  logic [YW-1:0] req_y,
    input  logic [FW-1:0] req_frame,
    output logic          req_ready,
    output logic          sprite_valid,
    output logic [XW-1:0] sprite_x,
    output logic [YW-1:0] sprite_y,
    output logic [FW-1:0] sprite_frame,
    input  logic          sprite_ready,
    output logic [CW-1:0] sprite_count,
    output logic [15:0]   drop_count
);

    typedef enum logic [1:0] {
        S_WAIT_FRAME = 2'd0,
        S_CURSOR     = 2'd1,
        S_GAME       = 2'd2,
        S_FULL       = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_cur_en;
    logic [XW-1:0] r_cur_x;
    logic [YW-1:0] r_cur_y;
    logic          r_valid;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [FW-1:0] r_frame;
    logic [CW-1:0] r_count;
    logic [15:0]   r_drop;

    logic          w_slot_free;
    logic          w_under_budget;
    logic          w_at_limit;
    logic [CW-1:0] w_count_inc;
    logic [XW-1:0] w_clamp_x;
    logic [YW-1:0] w_clamp_y;
    logic          w_req_ready;
    logic          w_load;
    logic [XW-1:0] w_load_x;
    logic [YW-1:0] w_load_y;
    logic [FW-1:0] w_load_frame;
    logic          w_drop;

    assign w_slot_free    = !r_valid || sprite_ready;
    assign w_under_budget = r_count < CW'(MAX_SPRITES);
    assign w_count_inc    = r_count + CW'(1);
    assign w_at_limit     = (w_count_inc == CW'(MAX_SPRITES));
    assign w_clamp_x = (32'(cursor_x) >= CANVAS_WIDTH)  ? XW'(CANVAS_WIDTH - 1)  : cursor_x;
    assign w_clamp_y = (32'(cursor_y) >= CANVAS_HEIGHT) ? YW'(CANVAS_HEIGHT - 1) : cursor_y;

    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 1'b0;
        w_load       = 1'b0;
        w_load_x     = req_x;
        w_load_y     = req_y;
        w_load_frame = req_frame;
        w_drop       = 1'b0;
        if (new_frame) begin
            // Frame start pre-empts everything; no load or consume this cycle.
            w_state_nxt = cursor_en ? S_CURSOR : S_GAME;
        end else begin
            case (r_state)
                S_WAIT_FRAME: w_state_nxt = S_WAIT_FRAME;
                S_CURSOR: begin
                    if (!r_cur_en) begin
                        w_state_nxt = S_GAME;
                    end else if (w_slot_free) begin
                        w_load       = 1'b1;
                        w_load_x     = r_cur_x;
                        w_load_y     = r_cur_y;
                        w_load_frame = FW'(CURSOR_FRAME);
                        w_state_nxt  = w_at_limit ? S_FULL : S_GAME;
                    end
                end
                S_GAME: begin
                    w_req_ready = w_slot_free && w_under_budget;
                    if (req_valid && w_req_ready) begin
                        w_load      = 1'b1;
                        w_state_nxt = w_at_limit ? S_FULL : S_GAME;
                    end
                end
                S_FULL: begin
                    // Over budget: swallow requests so the processor never stalls.
                    w_req_ready = 1'b1;
                    w_drop      = req_valid;
                end
                default: w_state_nxt = S_WAIT_FRAME;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= S_WAIT_FRAME;
            r_cur_en <= 1'b0;
            r_cur_x  <= '0;
            r_cur_y  <= '0;
            r_valid  <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_frame  <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (new_frame) begin
                r_cur_en <= cursor_en;
                r_cur_x  <= w_clamp_x;
                r_cur_y  <= w_clamp_y;
                r_count  <= '0;
            end else if (w_load) begin
                r_count <= w_count_inc;
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_x     <= w_load_x;
                r_y     <= w_load_y;
                r_frame <= w_load_frame;
            end else if (sprite_ready) begin
                r_valid <= 1'b0;
            end
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign req_ready    = w_req_ready;
    assign sprite_valid = r_valid;
    assign sprite_x     = r_x;
    assign sprite_y     = r_y;
    assign sprite_frame = r_frame;
    assign sprite_count = r_count;
    assign drop_count   = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_sprite_issue_arbiter.sv
// ============================================================================
//  tb_sprite_issue_arbiter : directed checks on default, 4- and 1-budget units
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_sprite_issue_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       new_frame, cursor_en, req_valid, sprite_ready;
    logic [8:0] cursor_x, req_x;
    logic [9:0] cursor_y, req_y;
    logic [2:0] req_frame;

    logic       a_req_ready, a_valid;
    logic [8:0] a_x;
    logic [9:0] a_y;
    logic [2:0] a_frame;
    logic [6:0] a_count;
    logic [15:0] a_drop;

    logic       b_req_ready, b_valid;
    logic [8:0] b_x;
    logic [9:0] b_y;
    logic [2:0] b_frame;
    logic [2:0] b_count;
    logic [15:0] b_drop;

    logic       c_req_ready, c_valid;
    logic [8:0] c_x;
    logic [9:0] c_y;
    logic [2:0] c_frame;
    logic [0:0] c_count;
    logic [15:0] c_drop;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sprite_issue_arbiter dut_a (
        .clk_in(clk), .rst_in(rst_n), .new_frame(new_frame), .cursor_en(cursor_en),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .req_valid(req_valid), .req_x(req_x),
        .req_y(req_y), .req_frame(req_frame), .req_ready(a_req_ready),
        .sprite_valid(a_valid), .sprite_x(a_x), .sprite_y(a_y), .sprite_frame(a_frame),
        .sprite_ready(sprite_ready), .sprite_count(a_count), .drop_count(a_drop)
    );

    sprite_issue_arbiter #(.MAX_SPRITES(4)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .new_frame(new_frame), .cursor_en(cursor_en),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .req_valid(req_valid), .req_x(req_x),
        .req_y(req_y), .req_frame(req_frame), .req_ready(b_req_ready),
        .sprite_valid(b_valid), .sprite_x(b_x), .sprite_y(b_y), .sprite_frame(b_frame),
        .sprite_ready(sprite_ready), .sprite_count(b_count), .drop_count(b_drop)
    );

    sprite_issue_arbiter #(.MAX_SPRITES(1)) dut_c (
        .clk_in(clk), .rst_in(rst_n), .new_frame(new_frame), .cursor_en(cursor_en),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .req_valid(req_valid), .req_x(req_x),
        .req_y(req_y), .req_frame(req_frame), .req_ready(c_req_ready),
        .sprite_valid(c_valid), .sprite_x(c_x), .sprite_y(c_y), .sprite_frame(c_frame),
        .sprite_ready(sprite_ready), .sprite_count(c_count), .drop_count(c_drop)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle frame pulse; req_ready must be low during it.
    task automatic pulse_frame(input logic en, input logic [8:0] x, input logic [9:0] y);
        new_frame = 1'b1;
        cursor_en = en;
        cursor_x  = x;
        cursor_y  = y;
        #1;
        vectors++;
        if (a_req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_req_ready: got %b want 0", a_req_ready);
        end
        cyc();
        new_frame = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; new_frame = 1'b0; cursor_en = 1'b0; cursor_x = '0; cursor_y = '0;
        req_valid = 1'b0; req_x = '0; req_y = '0; req_frame = '0; sprite_ready = 1'b1;
        #3;
        vectors++;
        if (a_valid !== 1'b0 || a_count !== 7'd0 || a_drop !== 16'd0 || a_req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b count=%0d drop=%0d rdy=%b want 0/0/0/0",
                     a_valid, a_count, a_drop, a_req_ready);
        end
        vectors++;
        if (a_x !== 9'd0 || a_y !== 10'd0 || a_frame !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_fields: got (%0d,%0d,%0d) want (0,0,0)", a_x, a_y, a_frame);
        end
        cyc();
        rst_n = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++;
            if (a_req_ready !== 1'b0 || a_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_frame_idle: rdy=%b valid=%b want 0/0", a_req_ready, a_valid);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_cursor();
        sprite_ready = 1'b1;
        pulse_frame(1'b1, 9'd100, 10'd200);
        vectors++;
        if (a_valid !== 1'b0 || a_count !== 7'd0) begin
            miscompares++;
            $display("FAIL cursor_state_entry: valid=%b count=%0d want 0/0", a_valid, a_count);
        end
        cyc();
        vectors++;
        if (a_valid !== 1'b1 || a_x !== 9'd100 || a_y !== 10'd200 || a_frame !== 3'd0) begin
            miscompares++;
            $display("FAIL cursor_issue: valid=%b (%0d,%0d,%0d) want 1 (100,200,0)",
                     a_valid, a_x, a_y, a_frame);
        end
        vectors++;
        if (a_count !== 7'd1 || a_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cursor_count_ready: count=%0d rdy=%b want 1/1", a_count, a_req_ready);
        end
        cyc();
        vectors++;
        if (a_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cursor_drain: valid=%b want 0", a_valid);
        end
    endtask

    task automatic test_clamp();
        pulse_frame(1'b1, 9'd400, 10'd800);
        cyc();
        vectors++;
        if (a_x !== 9'd359 || a_y !== 10'd719) begin
            miscompares++;
            $display("FAIL clamp_over: got (%0d,%0d) want (359,719)", a_x, a_y);
        end
        pulse_frame(1'b1, 9'd360, 10'd718);
        cyc();
        vectors++;
        if (a_x !== 9'd359 || a_y !== 10'd718) begin
            miscompares++;
            $display("FAIL clamp_edge: got (%0d,%0d) want (359,718)", a_x, a_y);
        end
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_x = 9'd10; req_y = 10'd20; req_frame = 3'd1;
        cyc();
        vectors++;
        if (a_valid !== 1'b1 || a_x !== 9'd10 || a_count !== 7'd2) begin
            miscompares++;
            $display("FAIL bp_first_load: valid=%b x=%0d count=%0d want 1/10/2", a_valid, a_x, a_count);
        end
        sprite_ready = 1'b0;
        req_x = 9'd11; req_y = 10'd21; req_frame = 3'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (a_req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_ready_low: cycle %0d rdy=%b want 0", i, a_req_ready);
            end
            cyc();
            vectors++;
            if (a_valid !== 1'b1 || a_x !== 9'd10 || a_y !== 10'd20 || a_frame !== 3'd1) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d valid=%b (%0d,%0d,%0d) want 1 (10,20,1)",
                         i, a_valid, a_x, a_y, a_frame);
            end
        end
        sprite_ready = 1'b1;
        #1;
        vectors++;
        if (a_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready: rdy=%b want 1", a_req_ready);
        end
        cyc();
        req_valid = 1'b0;
        vectors++;
        if (a_valid !== 1'b1 || a_x !== 9'd11 || a_y !== 10'd21 || a_frame !== 3'd2 || a_count !== 7'd3) begin
            miscompares++;
            $display("FAIL bp_next_load: (%0d,%0d,%0d) count=%0d want (11,21,2) 3",
                     a_x, a_y, a_frame, a_count);
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_x = 9'(50 + i); req_y = 10'(60 + i); req_frame = 3'(i);
            cyc();
            vectors++;
            if (a_valid !== 1'b1 || a_x !== 9'(50 + i) || a_y !== 10'(60 + i) || a_frame !== 3'(i)) begin
                miscompares++;
                $display("FAIL b2b_issue: i=%0d valid=%b (%0d,%0d,%0d) want 1 (%0d,%0d,%0d)",
                         i, a_valid, a_x, a_y, a_frame, 50 + i, 60 + i, i);
            end
        end
        req_valid = 1'b0;
        vectors++;
        if (a_count !== 7'd7) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d want 7", a_count);
        end
    endtask

    task automatic test_budget();
        apply_reset();
        pulse_frame(1'b1, 9'd5, 10'd6);
        cyc();
        vectors++;
        if (b_valid !== 1'b1 || b_x !== 9'd5 || b_count !== 3'd1) begin
            miscompares++;
            $display("FAIL budget_cursor: valid=%b x=%0d count=%0d want 1/5/1", b_valid, b_x, b_count);
        end
        vectors++;
        if (c_count !== 1'd1 || c_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL max1_cursor_full: count=%0d rdy=%b want 1/1", c_count, c_req_ready);
        end
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_x = 9'(i); req_y = 10'(i); req_frame = 3'd3;
            #1;
            vectors++;
            if (b_req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL budget_ready: req %0d rdy=%b want 1", i, b_req_ready);
            end
            cyc();
            if (i < 3) begin
                vectors++;
                if (b_valid !== 1'b1 || b_x !== 9'(i)) begin
                    miscompares++;
                    $display("FAIL budget_issue: req %0d valid=%b x=%0d want 1/%0d", i, b_valid, b_x, i);
                end
            end
        end
        req_valid = 1'b0;
        vectors++;
        if (b_drop !== 16'd7 || b_count !== 3'd4 || b_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL budget_drops: drop=%0d count=%0d valid=%b want 7/4/0", b_drop, b_count, b_valid);
        end
        vectors++;
        if (c_drop !== 16'd10 || c_count !== 1'd1) begin
            miscompares++;
            $display("FAIL max1_drops: drop=%0d count=%0d want 10/1", c_drop, c_count);
        end
        vectors++;
        if (a_count !== 7'd11 || a_drop !== 16'd0) begin
            miscompares++;
            $display("FAIL big_budget: count=%0d drop=%0d want 11/0", a_count, a_drop);
        end
    endtask

    task automatic test_pending();
        sprite_ready = 1'b1;
        req_valid = 1'b1; req_x = 9'd77; req_y = 10'd88; req_frame = 3'd2;
        cyc();
        req_valid = 1'b0;
        sprite_ready = 1'b0;
        cyc();
        pulse_frame(1'b1, 9'd30, 10'd40);
        vectors++;
        if (a_valid !== 1'b1 || a_x !== 9'd77 || a_y !== 10'd88 || a_frame !== 3'd2 || a_count !== 7'd0) begin
            miscompares++;
            $display("FAIL pending_held: valid=%b (%0d,%0d,%0d) count=%0d want 1 (77,88,2) 0",
                     a_valid, a_x, a_y, a_frame, a_count);
        end
        cyc();
        vectors++;
        if (a_x !== 9'd77 || a_count !== 7'd0) begin
            miscompares++;
            $display("FAIL pending_wait: x=%0d count=%0d want 77/0", a_x, a_count);
        end
        sprite_ready = 1'b1;
        cyc();
        vectors++;
        if (a_valid !== 1'b1 || a_x !== 9'd30 || a_y !== 10'd40 || a_frame !== 3'd0 || a_count !== 7'd1) begin
            miscompares++;
            $display("FAIL pending_cursor: valid=%b (%0d,%0d,%0d) count=%0d want 1 (30,40,0) 1",
                     a_valid, a_x, a_y, a_frame, a_count);
        end
    endtask

    task automatic test_async_reset();
        sprite_ready = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (a_valid !== 1'b0 || b_drop !== 16'd0 || c_drop !== 16'd0 || a_count !== 7'd0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b bdrop=%0d cdrop=%0d count=%0d want 0/0/0/0",
                     a_valid, b_drop, c_drop, a_count);
        end
        cyc();
        rst_n = 1'b1;
        sprite_ready = 1'b1;
        req_valid = 1'b1; req_x = 9'd3; req_y = 10'd4; req_frame = 3'd4;
        for (int i = 0; i < 2; i++) begin
            cyc();
            vectors++;
            if (a_req_ready !== 1'b0 || a_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle: rdy=%b valid=%b want 0/0", a_req_ready, a_valid);
            end
        end
        pulse_frame(1'b0, 9'd1, 10'd1);
        #1;
        vectors++;
        if (a_req_ready !== 1'b1 || a_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL no_cursor_game: rdy=%b valid=%b want 1/0", a_req_ready, a_valid);
        end
        cyc();
        req_valid = 1'b0;
        vectors++;
        if (a_valid !== 1'b1 || a_x !== 9'd3 || a_frame !== 3'd4 || a_count !== 7'd1) begin
            miscompares++;
            $display("FAIL no_cursor_first: valid=%b x=%0d frame=%0d count=%0d want 1/3/4/1",
                     a_valid, a_x, a_frame, a_count);
        end
    endtask

    initial begin
        test_reset();
        test_cursor();
        test_clamp();
        test_backpressure();
        test_back_to_back();
        test_budget();
        test_pending();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
